// File: rtl/wx_pkg.sv
// ============================================================================
//  Module      : wx_pkg
//  Description : Shared AXI W-channel routing types and constants for wx.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package wx_pkg;

  localparam int W_ROUTE_DEPTH = 2;
  localparam int W_LEN_BITS    = 4;

  typedef enum logic [1:0] {
    SLV_S0      = 2'd0,
    SLV_S1      = 2'd1,
    SLV_S2      = 2'd2,
    SLV_DEFAULT = 2'd3
  } route_slave_t;

  typedef struct packed {
    logic                  master;
    route_slave_t          slave;
    logic [W_LEN_BITS-1:0] len;
  } route_entry_t;

endpackage
`default_nettype wire

// File: rtl/wx_route_fifo.sv
// ============================================================================
//  Module      : wx_route_fifo
//  Description : Circular in-order route queue; head is visible combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wx_route_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);
  import wx_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wx.sv
// ============================================================================
//  Module      : wx
//  Description : AXI W-channel router; forwards bursts master->slave in AW order.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module wx
  import wx_pkg::*;
#(
  parameter int ROUTE_DEPTH = W_ROUTE_DEPTH,
  parameter int LEN_BITS    = W_LEN_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      route_push,
  input  logic                      route_master,
  input  logic [1:0]                route_slave,
  input  logic [LEN_BITS-1:0]       route_len,
  output logic                      route_full,
  output logic                      wlast_err,
  input  logic [`AXI_DATA_BITS-1:0] WDATA_M0,
  input  logic [`AXI_STRB_BITS-1:0] WSTRB_M0,
  input  logic                      WLAST_M0,
  input  logic                      WVALID_M0,
  output logic                      WREADY_M0,
  input  logic [`AXI_DATA_BITS-1:0] WDATA_M1,
  input  logic [`AXI_STRB_BITS-1:0] WSTRB_M1,
  input  logic                      WLAST_M1,
  input  logic                      WVALID_M1,
  output logic                      WREADY_M1,
  output logic [`AXI_DATA_BITS-1:0] WDATA_S0,
  output logic [`AXI_STRB_BITS-1:0] WSTRB_S0,
  output logic                      WLAST_S0,
  output logic                      WVALID_S0,
  input  logic                      WREADY_S0,
  output logic [`AXI_DATA_BITS-1:0] WDATA_S1,
  output logic [`AXI_STRB_BITS-1:0] WSTRB_S1,
  output logic                      WLAST_S1,
  output logic                      WVALID_S1,
  input  logic                      WREADY_S1,
  output logic [`AXI_DATA_BITS-1:0] WDATA_S2,
  output logic [`AXI_STRB_BITS-1:0] WSTRB_S2,
  output logic                      WLAST_S2,
  output logic                      WVALID_S2,
  input  logic                      WREADY_S2
);

  localparam int EW = 3 + LEN_BITS;
  localparam int CW = $clog2(ROUTE_DEPTH) + 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [EW-1:0]             head;
  logic                      q_empty;
  logic [CW-1:0]             q_count;
  logic                      push_ok;
  logic                      head_m;
  route_slave_t              head_s;
  logic [LEN_BITS-1:0]       head_len;
  logic [`AXI_DATA_BITS-1:0] sel_data;
  logic [`AXI_STRB_BITS-1:0] sel_strb;
  logic                      sel_last;
  logic                      sel_valid;
  logic                      sel_ready;
  logic                      hs;
  logic                      pop;
  logic [LEN_BITS-1:0]       beat_cnt;

  assign push_ok  = route_push & ~route_full;
  assign head_m   = head[EW-1];
  assign head_s   = route_slave_t'(head[LEN_BITS+1:LEN_BITS]);
  assign head_len = head[LEN_BITS-1:0];

  assign sel_data  = head_m ? WDATA_M1  : WDATA_M0;
  assign sel_strb  = head_m ? WSTRB_M1  : WSTRB_M0;
  assign sel_last  = head_m ? WLAST_M1  : WLAST_M0;
  assign sel_valid = head_m ? WVALID_M1 : WVALID_M0;

  assign hs  = (state_q == ST_ACTIVE) & sel_valid & sel_ready;
  assign pop = hs & sel_last;

  wx_route_fifo #(
    .DEPTH (ROUTE_DEPTH),
    .WIDTH (EW)
  ) u_route_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (route_push),
    .pop   (pop),
    .din   ({route_master, route_slave, route_len}),
    .full  (route_full),
    .empty (q_empty),
    .count (q_count),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ACTIVE tracks a non-empty queue; the last entry leaving without a refill drops to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (push_ok) state_d = ST_ACTIVE;
      ST_ACTIVE: if (pop && !push_ok && q_count == CW'(1)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_ready = 1'b0;
    WREADY_M0 = 1'b0;
    WREADY_M1 = 1'b0;
    WDATA_S0  = '0; WSTRB_S0 = '0; WLAST_S0 = 1'b0; WVALID_S0 = 1'b0;
    WDATA_S1  = '0; WSTRB_S1 = '0; WLAST_S1 = 1'b0; WVALID_S1 = 1'b0;
    WDATA_S2  = '0; WSTRB_S2 = '0; WLAST_S2 = 1'b0; WVALID_S2 = 1'b0;
    if (state_q == ST_ACTIVE && !q_empty) begin
      case (head_s)
        SLV_S0: begin
          WDATA_S0 = sel_data; WSTRB_S0 = sel_strb;
          WLAST_S0 = sel_last; WVALID_S0 = sel_valid;
          sel_ready = WREADY_S0;
        end
        SLV_S1: begin
          WDATA_S1 = sel_data; WSTRB_S1 = sel_strb;
          WLAST_S1 = sel_last; WVALID_S1 = sel_valid;
          sel_ready = WREADY_S1;
        end
        SLV_S2: begin
          WDATA_S2 = sel_data; WSTRB_S2 = sel_strb;
          WLAST_S2 = sel_last; WVALID_S2 = sel_valid;
          sel_ready = WREADY_S2;
        end
        default: sel_ready = 1'b1;  // default sink swallows every beat
      endcase
      if (head_m) WREADY_M1 = sel_ready;
      else        WREADY_M0 = sel_ready;
    end
  end

  // Count mismatches are only reported; the master's WLAST alone ends a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      wlast_err <= 1'b0;
    end else begin
      wlast_err <= hs & (sel_last != (beat_cnt == head_len));
      if (hs) beat_cnt <= sel_last ? '0 : beat_cnt + LEN_BITS'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wx.sv
// ============================================================================
//  Module      : tb_wx
//  Description : Directed self-checking bench for the wx W-channel router.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_wx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        route_push = 1'b0;
  logic        route_master = 1'b0;
  logic [1:0]  route_slave = 2'd0;
  logic [3:0]  route_len = 4'd0;
  logic        route_full, wlast_err;
  logic [31:0] WDATA_M0 = '0, WDATA_M1 = '0;
  logic [3:0]  WSTRB_M0 = '0, WSTRB_M1 = '0;
  logic        WLAST_M0 = 0, WLAST_M1 = 0, WVALID_M0 = 0, WVALID_M1 = 0;
  logic        WREADY_M0, WREADY_M1;
  logic [31:0] WDATA_S0, WDATA_S1, WDATA_S2;
  logic [3:0]  WSTRB_S0, WSTRB_S1, WSTRB_S2;
  logic        WLAST_S0, WLAST_S1, WLAST_S2;
  logic        WVALID_S0, WVALID_S1, WVALID_S2;
  logic        WREADY_S0 = 0, WREADY_S1 = 0, WREADY_S2 = 0;

  int passes = 0;
  int total  = 0;

  wx dut (
    .clk(clk), .rst_n(rst_n),
    .route_push(route_push), .route_master(route_master),
    .route_slave(route_slave), .route_len(route_len),
    .route_full(route_full), .wlast_err(wlast_err),
    .WDATA_M0(WDATA_M0), .WSTRB_M0(WSTRB_M0), .WLAST_M0(WLAST_M0),
    .WVALID_M0(WVALID_M0), .WREADY_M0(WREADY_M0),
    .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WLAST_M1(WLAST_M1),
    .WVALID_M1(WVALID_M1), .WREADY_M1(WREADY_M1),
    .WDATA_S0(WDATA_S0), .WSTRB_S0(WSTRB_S0), .WLAST_S0(WLAST_S0),
    .WVALID_S0(WVALID_S0), .WREADY_S0(WREADY_S0),
    .WDATA_S1(WDATA_S1), .WSTRB_S1(WSTRB_S1), .WLAST_S1(WLAST_S1),
    .WVALID_S1(WVALID_S1), .WREADY_S1(WREADY_S1),
    .WDATA_S2(WDATA_S2), .WSTRB_S2(WSTRB_S2), .WLAST_S2(WLAST_S2),
    .WVALID_S2(WVALID_S2), .WREADY_S2(WREADY_S2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #3.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic m, input logic [1:0] s, input logic [3:0] l);
    route_push = 1'b1; route_master = m; route_slave = s; route_len = l;
  endtask

  logic [4:0] rdy_pat;
  int         beats;

  initial begin
    #12;
    chk("rst_full", route_full, 0);
    chk("rst_err", wlast_err, 0);
    chk("rst_rdy_m0", WREADY_M0, 0);
    chk("rst_vld_s0", WVALID_S0, 0);
    rst_n = 1'b1;

    // Single beat M1 -> S1
    step(); push(1'b1, 2'd1, 4'd0);
    step(); route_push = 0;
    WDATA_M1 = 32'hDEADBEEF; WLAST_M1 = 1; WVALID_M1 = 1; WREADY_S1 = 1;
    #3;
    chk("sb_vld_s1", WVALID_S1, 1);
    chk("sb_data_s1", WDATA_S1, 32'hDEADBEEF);
    chk("sb_last_s1", WLAST_S1, 1);
    chk("sb_rdy_m1", WREADY_M1, 1);
    chk("sb_rdy_m0", WREADY_M0, 0);
    step(); WVALID_M1 = 0; WLAST_M1 = 0; WREADY_S1 = 0;
    #3;
    chk("sb_empty_rdy", WREADY_M1, 0);
    chk("sb_full", route_full, 0);
    chk("sb_err", wlast_err, 0);

    // Burst M1 -> S0, len=3, ready pattern 1,0,1,1,1
    step(); push(1'b1, 2'd0, 4'd3);
    step(); route_push = 0;
    rdy_pat = 5'b11101;
    beats = 0;
    for (int c = 0; c < 5; c++) begin
      WVALID_M1 = 1; WDATA_M1 = 32'(beats + 1); WLAST_M1 = (beats == 3);
      WREADY_S0 = rdy_pat[c];
      #3;
      chk("bu_data_s0", WDATA_S0, 32'(beats + 1));
      chk("bu_vld_s1", WVALID_S1, 0);
      chk("bu_vld_s2", WVALID_S2, 0);
      if (rdy_pat[c]) beats++;
      step();
    end
    WVALID_M1 = 0; WLAST_M1 = 0; WREADY_S0 = 0;
    #3;
    chk("bu_beats", beats, 4);
    chk("bu_popped", WREADY_M1, 0);
    chk("bu_err", wlast_err, 0);

    // In-order queue with a dropped third push
    step(); push(1'b0, 2'd2, 4'd0);
    step(); push(1'b1, 2'd1, 4'd1);
    step(); push(1'b0, 2'd0, 4'd0);
    #3;
    chk("q_full", route_full, 1);
    step(); route_push = 0;
    WVALID_M0 = 1; WDATA_M0 = 32'hA0; WLAST_M0 = 1; WREADY_S2 = 1;
    WVALID_M1 = 1; WDATA_M1 = 32'hB0; WLAST_M1 = 0; WREADY_S1 = 1;
    #3;
    chk("q_full_kept", route_full, 1);
    chk("q_vld_s2", WVALID_S2, 1);
    chk("q_data_s2", WDATA_S2, 32'hA0);
    chk("q_m1_wait", WREADY_M1, 0);
    chk("q_s1_idle", WVALID_S1, 0);
    step(); WVALID_M0 = 0; WLAST_M0 = 0;
    #3;
    chk("q_notfull", route_full, 0);
    chk("q_s1_b0", WDATA_S1, 32'hB0);
    chk("q_rdy_m1", WREADY_M1, 1);
    chk("q_s2_done", WVALID_S2, 0);
    step(); WDATA_M1 = 32'hB1; WLAST_M1 = 1;
    #3;
    chk("q_s1_b1", WDATA_S1, 32'hB1);
    chk("q_s1_last", WLAST_S1, 1);
    step(); WVALID_M1 = 0; WLAST_M1 = 0; WVALID_M0 = 1;
    WREADY_S0 = 1; WREADY_S1 = 0; WREADY_S2 = 0;
    #3;
    chk("q_drop_m0", WREADY_M0, 0);
    chk("q_drop_s0", WVALID_S0, 0);
    WVALID_M0 = 0; WREADY_S0 = 0;

    // Default sink
    step(); push(1'b0, 2'd3, 4'd1);
    step(); route_push = 0;
    WVALID_M0 = 1; WDATA_M0 = 32'h11; WLAST_M0 = 0;
    #3;
    chk("ds_rdy0", WREADY_M0, 1);
    chk("ds_vld_any0", {WVALID_S0, WVALID_S1, WVALID_S2}, 0);
    step(); WLAST_M0 = 1;
    #3;
    chk("ds_rdy1", WREADY_M0, 1);
    chk("ds_vld_any1", {WVALID_S0, WVALID_S1, WVALID_S2}, 0);
    step(); WVALID_M0 = 0; WLAST_M0 = 0;
    #3;
    chk("ds_popped", WREADY_M0, 0);
    chk("ds_err", wlast_err, 0);

    // Early WLAST on beat 2 of a len=3 burst
    step(); push(1'b1, 2'd0, 4'd3);
    step(); push(1'b0, 2'd1, 4'd0);
    step(); route_push = 0;
    WVALID_M1 = 1; WDATA_M1 = 32'h21; WLAST_M1 = 0; WREADY_S0 = 1;
    step(); WDATA_M1 = 32'h22; WLAST_M1 = 1;
    #3;
    chk("we_no_err_b0", wlast_err, 0);
    chk("we_vld_s0", WVALID_S0, 1);
    step(); WVALID_M1 = 0; WLAST_M1 = 0; WREADY_S0 = 0;
    WVALID_M0 = 1; WDATA_M0 = 32'h33; WLAST_M0 = 1; WREADY_S1 = 1;
    #3;
    chk("we_err", wlast_err, 1);
    chk("we_next_vld", WVALID_S1, 1);
    chk("we_next_rdy", WREADY_M0, 1);
    step(); WVALID_M0 = 0; WLAST_M0 = 0; WREADY_S1 = 0;
    #3;
    chk("we_err_pulse", wlast_err, 0);
    chk("we_empty", WREADY_M0, 0);

    // Reset mid-burst
    step(); push(1'b1, 2'd0, 4'd3);
    step(); route_push = 0;
    WVALID_M1 = 1; WDATA_M1 = 32'h41; WLAST_M1 = 0; WREADY_S0 = 1;
    step(); WDATA_M1 = 32'h42;
    #2;
    chk("rm_vld_pre", WVALID_S0, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_vld_s0", WVALID_S0, 0);
    chk("rm_rdy_m1", WREADY_M1, 0);
    chk("rm_data_s0", WDATA_S0, 0);
    WVALID_M1 = 0; WREADY_S0 = 0;
    step(); rst_n = 1'b1;
    #3;
    chk("rm_full", route_full, 0);
    step(); push(1'b0, 2'd0, 4'd0);
    #3;
    chk("rm_cnt0", route_full, 0);
    step(); push(1'b0, 2'd0, 4'd0);
    #3;
    chk("rm_cnt1", route_full, 0);
    step(); route_push = 0;
    #3;
    chk("rm_cnt2", route_full, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
